// File: rtl/irq_pending_dispatcher_pkg.sv
// Shared types and constants for the interrupt pending dispatcher.
// Bus/channel geometry, FSM state encoding and request index helper.
package irq_pkg;

  localparam int NCH  = 9;
  localparam int NBUS = 3;
  localparam int CHW  = 4;
  localparam int NREQ = NBUS * NCH;

  localparam int BUS_A = 0;
  localparam int BUS_B = 1;
  localparam int BUS_C = 2;

  typedef enum logic [1:0] {
    IDLE,
    SETTLE_WAIT,
    DISPATCH
  } state_t;

  // Flat request index; 6 bits covers out-of-range channels too.
  function automatic logic [5:0] flat_idx(
    input logic [1:0]     bus,
    input logic [CHW-1:0] ch
  );
    return 6'(int'(bus) * NCH + int'(ch));
  endfunction

endpackage

// File: rtl/irq_pending_dispatcher_bank.sv
// Pending request register bank for the interrupt dispatcher.
// Set beats clear on the same bit; reports any enabled pending request.
module irq_pending_bank
  import irq_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic [NREQ-1:0] set,
  input  logic [NREQ-1:0] clr,
  input  logic [NCH-1:0]  en,
  output logic [NREQ-1:0] pending,
  output logic            any_en
);

  // Pending bits: clear accepted request, then OR in new set pulses.
  always_ff @(posedge clk) begin
    if (rst) pending <= '0;
    else     pending <= (pending & ~clr) | set;
  end

  // Any pending request whose channel is currently enabled.
  always_comb begin
    any_en = |(pending & {NBUS{en}});
  end

endmodule

// File: rtl/irq_pending_dispatcher.sv
// Requester side of the 27-channel priority interrupt encoder.
// Queues requests, samples the settled grant, offers it to a servicer.
module irq_pending_dispatcher
  import irq_pkg::*;
#(
  parameter int SETTLE = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [NREQ-1:0] req_set,
  input  logic [NCH-1:0]  chan_en,
  output logic [NREQ-1:0] ctl_req,
  output logic [NCH-1:0]  ctl_en,
  input  logic            ctl_pa,
  input  logic            ctl_pb,
  input  logic            ctl_pc,
  input  logic [CHW-1:0]  ctl_chan,
  output logic            ack_valid,
  output logic [1:0]      ack_bus,
  output logic [CHW-1:0]  ack_chan,
  input  logic            ack_ready,
  output logic            busy,
  output logic            err_pulse
);

  localparam logic [3:0] SETTLE_LD = 4'(SETTLE - 1);

  state_t          state;
  logic [3:0]      cnt;
  logic [NREQ-1:0] pending;
  logic [NREQ-1:0] clr;
  logic            any_en;
  logic            sel_hit;
  logic [1:0]      sel_bus;
  logic            grant_ok;

  irq_pending_bank u_bank (
    .clk     (clk),
    .rst     (rst),
    .set     (req_set),
    .clr     (clr),
    .en      (ctl_en),
    .pending (pending),
    .any_en  (any_en)
  );

  assign ctl_req = pending;
  assign busy    = (state != IDLE);

  // Enables reach the encoder one cycle late, alongside pending.
  always_ff @(posedge clk) begin
    if (rst) ctl_en <= '0;
    else     ctl_en <= chan_en;
  end

  // One-hot clear for the request accepted this cycle.
  always_comb begin
    clr = '0;
    if (ack_valid && ack_ready)
      clr = NREQ'(1) << flat_idx(ack_bus, ack_chan);
  end

  // Pick the highest-priority granted bus and validate the result.
  always_comb begin
    sel_hit = ctl_pa | ctl_pb | ctl_pc;
    sel_bus = 2'(BUS_C);
    priority case (1'b1)
      ctl_pa:  sel_bus = 2'(BUS_A);
      ctl_pb:  sel_bus = 2'(BUS_B);
      default: sel_bus = 2'(BUS_C);
    endcase
    grant_ok = sel_hit
      && (ctl_chan < CHW'(NCH))
      && |(pending & (NREQ'(1) << flat_idx(sel_bus, ctl_chan)))
      && |(ctl_en & (NCH'(1) << ctl_chan));
  end

  // Dispatch FSM: wait for settle, sample grant, hold offer until ready.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      ack_valid <= 1'b0;
      ack_bus   <= '0;
      ack_chan  <= '0;
      err_pulse <= 1'b0;
    end else begin
      err_pulse <= 1'b0;
      unique case (state)
        IDLE: begin
          if (any_en) begin
            state <= SETTLE_WAIT;
            cnt   <= SETTLE_LD;
          end
        end
        SETTLE_WAIT: begin
          if (cnt != 4'd0) begin
            cnt <= cnt - 4'd1;
          end else if (grant_ok) begin
            state     <= DISPATCH;
            ack_valid <= 1'b1;
            ack_bus   <= sel_bus;
            ack_chan  <= ctl_chan;
          end else begin
            state     <= IDLE;
            err_pulse <= 1'b1;
          end
        end
        DISPATCH: begin
          if (ack_ready) begin
            state     <= IDLE;
            ack_valid <= 1'b0;
          end
        end
        default: begin
          state     <= IDLE;
          ack_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_irq_pending_dispatcher.sv
// Directed bench for irq_pending_dispatcher with a behavioural encoder.
// Encoder: bus A over B over C, lowest enabled channel wins.
module tb_irq_pending_dispatcher;
  import irq_pkg::*;

  logic            clk = 1'b0;
  logic            rst;
  logic [NREQ-1:0] req_set;
  logic [NCH-1:0]  chan_en;
  logic [NREQ-1:0] ctl_req;
  logic [NCH-1:0]  ctl_en;
  logic            ctl_pa, ctl_pb, ctl_pc;
  logic [CHW-1:0]  ctl_chan;
  logic            ack_valid;
  logic [1:0]      ack_bus;
  logic [CHW-1:0]  ack_chan;
  logic            ack_ready;
  logic            busy;
  logic            err_pulse;
  logic            kill;

  int checks = 0;
  int errors = 0;

  irq_pending_dispatcher #(.SETTLE(1)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_set   (req_set),
    .chan_en   (chan_en),
    .ctl_req   (ctl_req),
    .ctl_en    (ctl_en),
    .ctl_pa    (ctl_pa),
    .ctl_pb    (ctl_pb),
    .ctl_pc    (ctl_pc),
    .ctl_chan  (ctl_chan),
    .ack_valid (ack_valid),
    .ack_bus   (ack_bus),
    .ack_chan  (ack_chan),
    .ack_ready (ack_ready),
    .busy      (busy),
    .err_pulse (err_pulse)
  );

  always #5 clk = ~clk;

  always @* begin
    logic found;
    found    = 1'b0;
    ctl_pa   = 1'b0;
    ctl_pb   = 1'b0;
    ctl_pc   = 1'b0;
    ctl_chan = '0;
    for (int b = 0; b < NBUS; b++)
      for (int c = 0; c < NCH; c++)
        if (!kill && !found && ctl_req[b*NCH+c] && ctl_en[c]) begin
          found    = 1'b1;
          ctl_chan = CHW'(c);
          if (b == 0) ctl_pa = 1'b1;
          else if (b == 1) ctl_pb = 1'b1;
          else ctl_pc = 1'b1;
        end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_offer(input int max, output int n);
    n = 0;
    while (!ack_valid && n < max) begin
      tick();
      n++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    req_set = '0;
    chan_en = '0;
    ack_ready = 1'b0;
    kill = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    checks++;
    if ({ack_valid, busy, err_pulse} !== 3'b000) begin
      errors++;
      $display("FAIL reset_flags: got %b want 000",
               {ack_valid, busy, err_pulse});
    end
    checks++;
    if (ctl_req !== '0 || ctl_en !== '0) begin
      errors++;
      $display("FAIL reset_regs: got req=%h en=%h want 0/0",
               ctl_req, ctl_en);
    end
  endtask

  task automatic test_single();
    chan_en = 9'h1FF;
    tick();
    req_set = NREQ'(1) << 4;
    tick();
    req_set = '0;
    checks++;
    if (ctl_req !== (NREQ'(1) << 4) || ack_valid !== 1'b0) begin
      errors++;
      $display("FAIL single_n1: got req=%h av=%b want 10/0",
               ctl_req, ack_valid);
    end
    tick();
    checks++;
    if (busy !== 1'b1 || ack_valid !== 1'b0) begin
      errors++;
      $display("FAIL single_n2: got busy=%b av=%b want 1/0",
               busy, ack_valid);
    end
    tick();
    checks++;
    if (ack_valid !== 1'b1 || ack_bus !== 2'd0 || ack_chan !== 4'd4) begin
      errors++;
      $display("FAIL single_n3: got v=%b bus=%0d ch=%0d want 1/0/4",
               ack_valid, ack_bus, ack_chan);
    end
    ack_ready = 1'b1;
    tick();
    ack_ready = 1'b0;
    checks++;
    if (ack_valid !== 1'b0 || ctl_req !== '0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL single_hs: got v=%b req=%h busy=%b want 0/0/0",
               ack_valid, ctl_req, busy);
    end
  endtask

  task automatic test_back_to_back();
    int n;
    req_set = (NREQ'(1) << 4) | (NREQ'(1) << 13);
    tick();
    req_set = '0;
    wait_offer(10, n);
    checks++;
    if (ack_valid !== 1'b1 || ack_bus !== 2'd0 || ack_chan !== 4'd4) begin
      errors++;
      $display("FAIL b2b_first: got v=%b bus=%0d ch=%0d want 1/0/4",
               ack_valid, ack_bus, ack_chan);
    end
    ack_ready = 1'b1;
    tick();
    ack_ready = 1'b0;
    wait_offer(10, n);
    checks++;
    if (ack_valid !== 1'b1 || ack_bus !== 2'd1 || ack_chan !== 4'd4) begin
      errors++;
      $display("FAIL b2b_second: got v=%b bus=%0d ch=%0d want 1/1/4",
               ack_valid, ack_bus, ack_chan);
    end
    checks++;
    if (n !== 2) begin
      errors++;
      $display("FAIL b2b_gap: got %0d want 2 ticks after handshake tick",
               n);
    end
    ack_ready = 1'b1;
    tick();
    ack_ready = 1'b0;
    checks++;
    if (ctl_req !== '0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL b2b_drain: got req=%h busy=%b want 0/0",
               ctl_req, busy);
    end
  endtask

  task automatic test_disabled();
    int n;
    int bad;
    chan_en = 9'h1EF;
    tick();
    req_set = NREQ'(1) << 4;
    tick();
    req_set = '0;
    bad = 0;
    for (int i = 0; i < 5; i++) begin
      if (busy !== 1'b0 || ack_valid !== 1'b0) bad++;
      tick();
    end
    checks++;
    if (bad != 0 || ctl_req !== (NREQ'(1) << 4)) begin
      errors++;
      $display("FAIL dis_idle: got bad=%0d req=%h want 0/10",
               bad, ctl_req);
    end
    chan_en = 9'h1FF;
    wait_offer(10, n);
    checks++;
    if (n !== 3 || ack_bus !== 2'd0 || ack_chan !== 4'd4) begin
      errors++;
      $display("FAIL dis_enable: got n=%0d bus=%0d ch=%0d want 3/0/4",
               n, ack_bus, ack_chan);
    end
    ack_ready = 1'b1;
    tick();
    ack_ready = 1'b0;
  endtask

  task automatic test_invalid();
    int n;
    kill = 1'b1;
    req_set = NREQ'(1) << 20;
    tick();
    req_set = '0;
    tick();
    checks++;
    if (busy !== 1'b1 || err_pulse !== 1'b0) begin
      errors++;
      $display("FAIL inv_wait: got busy=%b err=%b want 1/0",
               busy, err_pulse);
    end
    tick();
    checks++;
    if (err_pulse !== 1'b1 || busy !== 1'b0 || ack_valid !== 1'b0
        || ctl_req !== (NREQ'(1) << 20)) begin
      errors++;
      $display("FAIL inv_err: got err=%b busy=%b v=%b req=%h want 1/0/0/100000",
               err_pulse, busy, ack_valid, ctl_req);
    end
    tick();
    checks++;
    if (err_pulse !== 1'b0) begin
      errors++;
      $display("FAIL inv_pulse_len: got %b want 0", err_pulse);
    end
    kill = 1'b0;
    wait_offer(10, n);
    checks++;
    if (ack_valid !== 1'b1 || ack_bus !== 2'd2 || ack_chan !== 4'd2) begin
      errors++;
      $display("FAIL inv_recover: got v=%b bus=%0d ch=%0d want 1/2/2",
               ack_valid, ack_bus, ack_chan);
    end
    ack_ready = 1'b1;
    tick();
    ack_ready = 1'b0;
  endtask

  task automatic test_hold_requeue();
    int n;
    int bad;
    req_set = NREQ'(1) << 13;
    tick();
    req_set = '0;
    wait_offer(10, n);
    bad = 0;
    chan_en = 9'h000;
    for (int i = 0; i < 10; i++) begin
      if (ack_valid !== 1'b1 || ack_bus !== 2'd1 || ack_chan !== 4'd4)
        bad++;
      tick();
    end
    chan_en = 9'h1FF;
    checks++;
    if (bad != 0 || ack_valid !== 1'b1) begin
      errors++;
      $display("FAIL hold_stable: got bad=%0d v=%b want 0/1",
               bad, ack_valid);
    end
    ack_ready = 1'b1;
    req_set = NREQ'(1) << 13;
    tick();
    ack_ready = 1'b0;
    req_set = '0;
    checks++;
    if (ack_valid !== 1'b0 || ctl_req !== (NREQ'(1) << 13)) begin
      errors++;
      $display("FAIL hold_requeue: got v=%b req=%h want 0/2000",
               ack_valid, ctl_req);
    end
    wait_offer(10, n);
    checks++;
    if (ack_valid !== 1'b1 || ack_bus !== 2'd1 || ack_chan !== 4'd4) begin
      errors++;
      $display("FAIL hold_reoffer: got v=%b bus=%0d ch=%0d want 1/1/4",
               ack_valid, ack_bus, ack_chan);
    end
    ack_ready = 1'b1;
    tick();
    ack_ready = 1'b0;
  endtask

  task automatic test_reset_dispatch();
    int n;
    req_set = (NREQ'(1) << 0) | (NREQ'(1) << 10) | (NREQ'(1) << 26);
    tick();
    req_set = '0;
    wait_offer(10, n);
    checks++;
    if (ack_valid !== 1'b1 || ack_bus !== 2'd0 || ack_chan !== 4'd0) begin
      errors++;
      $display("FAIL rstd_offer: got v=%b bus=%0d ch=%0d want 1/0/0",
               ack_valid, ack_bus, ack_chan);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++;
    if (ack_valid !== 1'b0 || ctl_req !== '0 || ctl_en !== '0
        || busy !== 1'b0 || ack_bus !== 2'd0 || ack_chan !== 4'd0) begin
      errors++;
      $display("FAIL rstd_clear: got v=%b req=%h en=%h busy=%b want 0/0/0/0",
               ack_valid, ctl_req, ctl_en, busy);
    end
    tick();
    tick();
    checks++;
    if (busy !== 1'b0 || ack_valid !== 1'b0) begin
      errors++;
      $display("FAIL rstd_quiet: got busy=%b v=%b want 0/0",
               busy, ack_valid);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_disabled();
    test_invalid();
    test_hold_requeue();
    test_reset_dispatch();
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule

// File: doc/irq_pending_dispatcher.md
Name: irq_pending_dispatcher

Overview:
- Requester-side companion to the combinational 27-channel priority interrupt encoder (3 buses A/B/C × 9 channels, 9 shared channel enables).
- Holds a pending-request register bank and drives it, with the enables, into the encoder.
- Waits out the encoder settle time, then samples the encoder's bus-grant flags and encoded channel and validates them.
- Offers the winning request to a service agent over a valid/ready acknowledge handshake; clears the pending bit on acceptance.

Parameters:
- NCH, 9, channels per bus.
- NBUS, 3, priority buses; index 0=A (highest), 1=B, 2=C (lowest).
- CHW, 4, width of the encoded channel index.
- SETTLE, 1, cycles allowed for the encoder outputs to settle before sampling; legal range 1..15.

Ports:
- clk  in  1  sole clock; all state updates on rising edge.
- rst  in  1  reset, synchronous, active-high.
- req_set  in  27  set-pulse per request; flat index = bus*9+ch.
- chan_en  in  9  channel enables, shared across buses.
- ctl_req  out  27  pending vector driven to the encoder.
- ctl_en  out  9  registered copy of chan_en driven to the encoder.
- ctl_pa, ctl_pb, ctl_pc  in  1 each  encoder bus-grant flags, active-high.
- ctl_chan  in  4  encoder winning-channel index.
- ack_valid  out  1  dispatch offer valid.
- ack_bus  out  2  bus of the offered request.
- ack_chan  out  4  channel of the offered request.
- ack_ready  in  1  service agent accepts the offer.
- busy  out  1  FSM not in IDLE.
- err_pulse  out  1  one-cycle flag: the encoder result was invalid.

Behaviour:
- Reset (synchronous, active-high): pending=0, ctl_en=0, FSM=IDLE, ack_valid=0, ack_bus=0, ack_chan=0, err_pulse=0, busy=0. Reset mid-handshake drops the offer and applies next edge; no pending bit survives reset.
- Pending update each edge: pending_next = (pending & ~clr_mask) | req_set.
  - clr_mask is one-hot for the accepted request only when ack_valid&ack_ready; otherwise 0.
  - If set and clear hit the same bit in one cycle, set wins and the request re-queues.
- ctl_req equals the pending register directly. ctl_en equals chan_en delayed one cycle.
- FSM states: IDLE, SETTLE_WAIT, DISPATCH.
  - IDLE: if any pending[b*9+c]&ctl_en[c] -> SETTLE_WAIT and load the settle counter with SETTLE-1. Otherwise stay.
  - SETTLE_WAIT: decrement the counter. At counter==0, sample the grant:
    - Selected bus = highest-priority asserted flag (pa over pb over pc).
    - Valid iff a flag is set, ctl_chan<9, pending[bus*9+ctl_chan]=1 and ctl_en[ctl_chan]=1.
    - Valid -> DISPATCH: register ack_bus/ack_chan, set ack_valid=1.
    - Invalid -> IDLE: err_pulse=1 for exactly one cycle, pending unchanged.
  - DISPATCH: ack_valid, ack_bus and ack_chan held stable until ack_ready. On handshake: clear the pending bit, ack_valid=0, -> IDLE. chan_en changes during DISPATCH do not cancel the offer.
- Latency: req_set pulsed in cycle N on an idle block -> pending visible N+1 -> ack_valid high from cycle N+2+SETTLE (N+3 at default).
- Back-to-back: after a handshake the FSM always passes through IDLE, so the minimum offer period is 2+SETTLE cycles plus ready delay.
- The encoder is combinational on registered inputs. The block never samples ctl_* outside the last SETTLE_WAIT cycle.
- busy = (state != IDLE).

Decomposition:
- Package irq_pkg:
  - NCH, NBUS, CHW, BUS_A=0, BUS_B=1, BUS_C=2.
  - State enum (IDLE, SETTLE_WAIT, DISPATCH).
  - Function flat_idx(bus, ch) returning bus*NCH+ch.
- Sub-module irq_pending_bank: 27-bit pending register with set/clear-priority rule and the any-enabled-pending reduction.
- Top holds the FSM, settle counter and grant validation.

Test Plan:
- Reset, then req_set bit 4 (A,ch4), chan_en=9'h1FF, encoder pa=1 chan=4 -> ack_valid rises cycle N+3, ack_bus=0, ack_chan=4. ack_ready same cycle -> pending=0, busy low next cycle.
- req_set bits 4 and 13 (B,ch4) together; encoder grants A then B -> two offers in order (0,4) then (1,4); second offer not before 3 cycles after the first handshake.
- chan_en[4]=0 with only bit 4 pending -> FSM stays IDLE, no offer, busy=0; enabling ch4 produces the offer 2+SETTLE cycles later.
- Encoder forced to pa=0,pb=0,pc=0 while bit 20 pending -> err_pulse high one cycle, pending bit 20 still set, FSM back in IDLE.
- In DISPATCH hold ack_ready=0 for 10 cycles, re-pulse req_set for the offered bit on the handshake cycle -> offer stable throughout; bit remains pending after the handshake (set wins).
- Assert rst during DISPATCH with 3 bits pending -> next cycle ack_valid=0, pending=0, ctl_en=0, state IDLE.
